// File: rtl/key_expansion_seq.sv
// rtl/key_expansion_seq.sv - sequential AES-128/192/256 key expander, one schedule word per clock
module key_expansion_seq #(
    parameter int NK = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [32*NK-1:0]  key_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              keys_valid,
    input  logic [3:0]        rk_addr,
    output logic [127:0]      rk_out
);

    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [5:0] NK_W      = 6'(NK);
    localparam logic [5:0] LAST_WORD = 6'(NW - 1);
    localparam logic [2:0] WRAP_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_W      = 4'(NR);

    // Forward S-box, byte 0x00 at the left end.
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXPAND,
        S_DONE
    } state_t;

    state_t      state;
    logic [31:0] w [NW];
    logic [5:0]  idx;
    logic [2:0]  wrap;
    logic [7:0]  rcon;
    logic [31:0] prev_word;
    logic [31:0] t_word;
    logic [31:0] new_word;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TABLE[{x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    always_comb begin
        prev_word = w[idx - 6'd1];
        t_word    = prev_word;
        if (wrap == 3'd0) begin
            t_word = sub_word({prev_word[23:0], prev_word[31:24]}) ^ {rcon, 24'h0};
        end else if (NK == 8 && wrap == 3'd4) begin
            t_word = sub_word(prev_word);
        end
        new_word = w[idx - NK_W] ^ t_word;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            idx        <= '0;
            wrap       <= '0;
            rcon       <= '0;
            for (int j = 0; j < NW; j++) begin
                w[j] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int j = 0; j < NK; j++) begin
                            w[j] <= key_in[32*(NK-1-j) +: 32];
                        end
                        idx        <= NK_W;
                        wrap       <= '0;
                        rcon       <= 8'h01;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    w[idx] <= new_word;
                    idx    <= idx + 6'd1;
                    wrap   <= (wrap == WRAP_LAST) ? 3'd0 : wrap + 3'd1;
                    if (wrap == 3'd0) begin
                        rcon <= xtime(rcon);
                    end
                    // The final word completes the schedule, so flag it in the same edge.
                    if (idx == LAST_WORD) begin
                        done       <= 1'b1;
                        keys_valid <= 1'b1;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rk_out = '0;
        if (keys_valid && rk_addr <= NR_W) begin
            rk_out = {w[{rk_addr, 2'b00}],
                      w[{rk_addr, 2'b01}],
                      w[{rk_addr, 2'b10}],
                      w[{rk_addr, 2'b11}]};
        end
    end

endmodule
